inta_sequencer: RTL and testbench

CPU-side interrupt-acknowledge initiator for the PIC subsystem. Watches the PIC's INT output and, when interrupts are enabled, generates the INTA pulse train on the acknowledge bus. After the final pulse it samples the 8-bit vector that the master or addressed slave drives onto the data bus, then hands the vector to the CPU core over a valid/ready handshake. It is the requesting end of the acknowledge protocol whose responding end is the PIC cascade/vector logic.

---
 rtl/pic_pkg.sv | 19 +
 rtl/inta_sequencer_if.sv | 26 ++
 rtl/inta_pulse_timer.sv | 27 ++
 rtl/inta_sequencer.sv | 108 ++++++++++
 tb/tb_inta_sequencer.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/pic_pkg.sv
// Shared types and defaults for the PIC acknowledge path.
package pic_pkg;

  localparam int VEC_W          = 8;
  localparam int TMR_W          = 4;
  localparam int NUM_PULSES_DEF = 2;
  localparam int PULSE_LOW_DEF  = 2;
  localparam int GAP_DEF        = 2;
  localparam int SETTLE_DEF     = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOW,
    ST_HIGH,
    ST_SETTLE,
    ST_HOLD
  } inta_state_t;

endpackage

// File: rtl/inta_sequencer_if.sv
// Acknowledge bus between the INTA sequencer, the PIC and the CPU core.
interface inta_sequencer_if;
  import pic_pkg::*;

  logic             int_req;
  logic             int_en;
  logic [VEC_W-1:0] data_in;
  logic             inta_n;
  // vec/vec_valid form a valid/ready pair: once vec_valid rises, vec is held
  // stable and vec_valid stays high until a cycle with vec_valid && vec_ready.
  logic [VEC_W-1:0] vec;
  logic             vec_valid;
  logic             vec_ready;
  logic             busy;

  modport master (
    input  int_req, int_en, data_in, vec_ready,
    output inta_n, vec, vec_valid, busy
  );

  modport slave (
    output int_req, int_en, data_in, vec_ready,
    input  inta_n, vec, vec_valid, busy
  );

endinterface

// File: rtl/inta_pulse_timer.sv
// Loadable down-counter; expire_o is high in the final cycle of a loaded interval.
module inta_pulse_timer
  import pic_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [TMR_W-1:0] load_val_i,
  output logic             expire_o
);

  logic [TMR_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  // A load of N therefore spans exactly N cycles before the next load.
  assign expire_o = (count_q == TMR_W'(1));

endmodule

// File: rtl/inta_sequencer.sv
// INTA pulse-train generator: acknowledges INT, samples the vector, hands it to the CPU.
module inta_sequencer
  import pic_pkg::*;
#(
  parameter int NUM_PULSES = NUM_PULSES_DEF,
  parameter int PULSE_LOW  = PULSE_LOW_DEF,
  parameter int GAP        = GAP_DEF,
  parameter int SETTLE     = SETTLE_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  inta_sequencer_if.master         bus,
  output inta_state_t              state_o
);

  inta_state_t      state_q;
  logic             req_q;
  logic [1:0]       pulse_cnt_q;
  logic             inta_n_q;
  logic [VEC_W-1:0] vec_q;
  logic             vec_valid_q;
  logic             busy_q;

  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_expire;
  logic             last_pulse;

  assign last_pulse = (pulse_cnt_q + 2'd1) == 2'(NUM_PULSES);

  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      ST_IDLE: if (req_q) begin
        tmr_load = 1'b1;
        tmr_val  = TMR_W'(PULSE_LOW);
      end
      ST_LOW: if (tmr_expire) begin
        tmr_load = 1'b1;
        tmr_val  = last_pulse ? TMR_W'(SETTLE) : TMR_W'(GAP);
      end
      ST_HIGH: if (tmr_expire) begin
        tmr_load = 1'b1;
        tmr_val  = TMR_W'(PULSE_LOW);
      end
      default: ;
    endcase
  end

  inta_pulse_timer u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .expire_o   (tmr_expire)
  );

  // req_q is the sampling edge; the train starts one edge later.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      req_q       <= 1'b0;
      pulse_cnt_q <= 2'd0;
      inta_n_q    <= 1'b1;
      vec_q       <= '0;
      vec_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      req_q <= bus.int_req && bus.int_en;
      case (state_q)
        ST_IDLE: if (req_q) begin
          state_q     <= ST_LOW;
          pulse_cnt_q <= 2'd0;
          inta_n_q    <= 1'b0;
          busy_q      <= 1'b1;
        end
        ST_LOW: if (tmr_expire) begin
          pulse_cnt_q <= pulse_cnt_q + 2'd1;
          inta_n_q    <= 1'b1;
          state_q     <= last_pulse ? ST_SETTLE : ST_HIGH;
        end
        ST_HIGH: if (tmr_expire) begin
          inta_n_q <= 1'b0;
          state_q  <= ST_LOW;
        end
        ST_SETTLE: if (tmr_expire) begin
          vec_q       <= bus.data_in;
          vec_valid_q <= 1'b1;
          state_q     <= ST_HOLD;
        end
        ST_HOLD: if (bus.vec_ready) begin
          vec_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.inta_n    = inta_n_q;
  assign bus.vec       = vec_q;
  assign bus.vec_valid = vec_valid_q;
  assign bus.busy      = busy_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_inta_sequencer.sv
// Directed bench for inta_sequencer: default 8086 timing on dut_a, 8080 timing on dut_b.
module tb_inta_sequencer;
  import pic_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  inta_state_t state_a, state_b;
  int          vectors = 0;
  int          miscompares = 0;

  inta_sequencer_if bus_a ();
  inta_sequencer_if bus_b ();

  inta_sequencer dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a), .state_o(state_a)
  );

  inta_sequencer #(
    .NUM_PULSES(3), .PULSE_LOW(1), .GAP(1), .SETTLE(2)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b), .state_o(state_b)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    vectors++; if (bus_a.inta_n !== 1'b1) begin miscompares++; $display("FAIL reset_inta_a got %b want 1", bus_a.inta_n); end
    vectors++; if (bus_a.vec !== 8'h00) begin miscompares++; $display("FAIL reset_vec_a got %h want 00", bus_a.vec); end
    vectors++; if (bus_a.vec_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid_a got %b want 0", bus_a.vec_valid); end
    vectors++; if (bus_a.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy_a got %b want 0", bus_a.busy); end
    vectors++; if (state_a !== ST_IDLE) begin miscompares++; $display("FAIL reset_state_a got %0d want %0d", state_a, ST_IDLE); end
    vectors++; if (bus_b.inta_n !== 1'b1 || bus_b.vec_valid !== 1'b0 || bus_b.busy !== 1'b0) begin
      miscompares++; $display("FAIL reset_b got inta_n=%b valid=%b busy=%b want 1/0/0", bus_b.inta_n, bus_b.vec_valid, bus_b.busy);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_default();
    logic [15:0] low_m;
    low_m = 16'h0066;
    bus_a.data_in = 8'h4B; bus_a.vec_ready = 1'b1; bus_a.int_en = 1'b1; bus_a.int_req = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      vectors++; if (bus_a.inta_n !== ~low_m[c]) begin miscompares++; $display("FAIL default_inta cyc %0d got %b want %b", c, bus_a.inta_n, ~low_m[c]); end
      vectors++; if (bus_a.busy !== (c >= 1 && c <= 8)) begin miscompares++; $display("FAIL default_busy cyc %0d got %b", c, bus_a.busy); end
      vectors++; if (bus_a.vec_valid !== (c == 8)) begin miscompares++; $display("FAIL default_valid cyc %0d got %b", c, bus_a.vec_valid); end
      if (c == 8) begin
        vectors++; if (bus_a.vec !== 8'h4B) begin miscompares++; $display("FAIL default_vec got %h want 4b", bus_a.vec); end
        bus_a.int_req = 1'b0;
      end
    end
  endtask

  task automatic test_int_en_gate();
    bus_a.int_req = 1'b1; bus_a.int_en = 1'b0; bus_a.data_in = 8'h5A; bus_a.vec_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      vectors++; if (bus_a.inta_n !== 1'b1 || bus_a.busy !== 1'b0) begin
        miscompares++; $display("FAIL gate_idle cyc %0d got inta_n=%b busy=%b want 1/0", c, bus_a.inta_n, bus_a.busy);
      end
    end
    bus_a.int_en = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (c == 0) begin
        vectors++; if (bus_a.inta_n !== 1'b1) begin miscompares++; $display("FAIL gate_edge0 got %b want 1", bus_a.inta_n); end
      end
      if (c == 1) begin
        vectors++; if (bus_a.inta_n !== 1'b0 || bus_a.busy !== 1'b1) begin
          miscompares++; $display("FAIL gate_start got inta_n=%b busy=%b want 0/1", bus_a.inta_n, bus_a.busy);
        end
      end
      if (c == 8) begin
        vectors++; if (bus_a.vec_valid !== 1'b1 || bus_a.vec !== 8'h5A) begin
          miscompares++; $display("FAIL gate_vec got valid=%b vec=%h want 1/5a", bus_a.vec_valid, bus_a.vec);
        end
        bus_a.int_req = 1'b0;
      end
      if (c == 9) begin
        vectors++; if (bus_a.busy !== 1'b0) begin miscompares++; $display("FAIL gate_done got busy=%b want 0", bus_a.busy); end
      end
    end
    bus_a.int_en = 1'b0;
  endtask

  task automatic test_three_pulse();
    logic [15:0] low_m;
    low_m = 16'h002A;
    bus_b.data_in = 8'h25; bus_b.vec_ready = 1'b1; bus_b.int_en = 1'b1; bus_b.int_req = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      vectors++; if (bus_b.inta_n !== ~low_m[c]) begin miscompares++; $display("FAIL three_inta cyc %0d got %b want %b", c, bus_b.inta_n, ~low_m[c]); end
      vectors++; if (bus_b.vec_valid !== (c == 8)) begin miscompares++; $display("FAIL three_valid cyc %0d got %b", c, bus_b.vec_valid); end
      vectors++; if (bus_b.busy !== (c >= 1 && c <= 8)) begin miscompares++; $display("FAIL three_busy cyc %0d got %b", c, bus_b.busy); end
      if (c == 8) begin
        vectors++; if (bus_b.vec !== 8'h25) begin miscompares++; $display("FAIL three_vec got %h want 25", bus_b.vec); end
        bus_b.int_req = 1'b0;
      end
    end
  endtask

  task automatic test_spurious_hold();
    logic [15:0] low_m;
    low_m = 16'h0066;
    bus_a.data_in = 8'h3C; bus_a.vec_ready = 1'b0; bus_a.int_en = 1'b1; bus_a.int_req = 1'b1;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (c == 2) bus_a.int_req = 1'b0;
      if (c == 6) bus_a.int_req = 1'b1;
      if (c < 8) begin
        vectors++; if (bus_a.inta_n !== ~low_m[c]) begin miscompares++; $display("FAIL spur_inta cyc %0d got %b want %b", c, bus_a.inta_n, ~low_m[c]); end
      end else if (c <= 12) begin
        vectors++; if (bus_a.vec_valid !== 1'b1 || bus_a.vec !== 8'h3C || bus_a.inta_n !== 1'b1 || bus_a.busy !== 1'b1) begin
          miscompares++; $display("FAIL hold cyc %0d got valid=%b vec=%h inta_n=%b busy=%b want 1/3c/1/1", c, bus_a.vec_valid, bus_a.vec, bus_a.inta_n, bus_a.busy);
        end
        if (c == 12) begin bus_a.vec_ready = 1'b1; bus_a.int_req = 1'b0; end
      end else begin
        vectors++; if (bus_a.vec_valid !== 1'b0 || bus_a.busy !== 1'b0 || bus_a.inta_n !== 1'b1) begin
          miscompares++; $display("FAIL hold_release cyc %0d got valid=%b busy=%b inta_n=%b want 0/0/1", c, bus_a.vec_valid, bus_a.busy, bus_a.inta_n);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] low_m;
    low_m = 16'h0066;
    bus_a.data_in = 8'h11; bus_a.vec_ready = 1'b1; bus_a.int_en = 1'b1; bus_a.int_req = 1'b1;
    for (int c = 0; c < 6; c++) tick();
    vectors++; if (bus_a.inta_n !== 1'b0) begin miscompares++; $display("FAIL rstmid_pre got inta_n=%b want 0", bus_a.inta_n); end
    rst_n = 1'b0;
    tick();
    vectors++; if (bus_a.inta_n !== 1'b1 || bus_a.vec_valid !== 1'b0 || bus_a.busy !== 1'b0 || bus_a.vec !== 8'h00) begin
      miscompares++; $display("FAIL rstmid_edge got inta_n=%b valid=%b busy=%b vec=%h want 1/0/0/00", bus_a.inta_n, bus_a.vec_valid, bus_a.busy, bus_a.vec);
    end
    vectors++; if (state_a !== ST_IDLE) begin miscompares++; $display("FAIL rstmid_state got %0d want %0d", state_a, ST_IDLE); end
    rst_n = 1'b1; bus_a.data_in = 8'h77;
    for (int c = 0; c < 10; c++) begin
      tick();
      vectors++; if (bus_a.inta_n !== ~low_m[c]) begin miscompares++; $display("FAIL rstmid_inta cyc %0d got %b want %b", c, bus_a.inta_n, ~low_m[c]); end
      vectors++; if (bus_a.vec_valid !== (c == 8)) begin miscompares++; $display("FAIL rstmid_valid cyc %0d got %b", c, bus_a.vec_valid); end
      if (c == 8) begin
        vectors++; if (bus_a.vec !== 8'h77) begin miscompares++; $display("FAIL rstmid_vec got %h want 77", bus_a.vec); end
        bus_a.int_req = 1'b0;
      end
    end
  endtask

  task automatic test_data_window();
    bus_a.data_in = 8'hFF; bus_a.vec_ready = 1'b1; bus_a.int_en = 1'b1; bus_a.int_req = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (c < 7) bus_a.data_in = (c == 3) ? 8'hxx : ((c % 2 == 0) ? 8'h00 : 8'hFF);
      else if (c == 7) bus_a.data_in = 8'h81;
      else bus_a.data_in = 8'hFF;
      if (c == 8) begin
        vectors++; if (bus_a.vec_valid !== 1'b1 || bus_a.vec !== 8'h81) begin
          miscompares++; $display("FAIL window_vec got valid=%b vec=%h want 1/81", bus_a.vec_valid, bus_a.vec);
        end
        bus_a.int_req = 1'b0;
      end
    end
  endtask

  task automatic test_back_to_back();
    bus_a.data_in = 8'hA5; bus_a.vec_ready = 1'b1; bus_a.int_en = 1'b1; bus_a.int_req = 1'b1;
    for (int c = 0; c < 19; c++) begin
      tick();
      if (c == 8) begin
        vectors++; if (bus_a.vec_valid !== 1'b1 || bus_a.vec !== 8'hA5) begin
          miscompares++; $display("FAIL b2b_first got valid=%b vec=%h want 1/a5", bus_a.vec_valid, bus_a.vec);
        end
        bus_a.data_in = 8'hC3;
      end
      if (c == 9) begin
        vectors++; if (bus_a.inta_n !== 1'b1 || bus_a.busy !== 1'b0 || state_a !== ST_IDLE) begin
          miscompares++; $display("FAIL b2b_idle got inta_n=%b busy=%b state=%0d want 1/0/idle", bus_a.inta_n, bus_a.busy, state_a);
        end
      end
      if (c == 10) begin
        vectors++; if (bus_a.inta_n !== 1'b0 || bus_a.busy !== 1'b1) begin
          miscompares++; $display("FAIL b2b_restart got inta_n=%b busy=%b want 0/1", bus_a.inta_n, bus_a.busy);
        end
        bus_a.int_req = 1'b0;
      end
      if (c == 17) begin
        vectors++; if (bus_a.vec_valid !== 1'b1 || bus_a.vec !== 8'hC3) begin
          miscompares++; $display("FAIL b2b_second got valid=%b vec=%h want 1/c3", bus_a.vec_valid, bus_a.vec);
        end
      end
      if (c == 18) begin
        vectors++; if (bus_a.busy !== 1'b0 || bus_a.vec_valid !== 1'b0) begin
          miscompares++; $display("FAIL b2b_done got busy=%b valid=%b want 0/0", bus_a.busy, bus_a.vec_valid);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus_a.int_req = 1'b0; bus_a.int_en = 1'b0; bus_a.data_in = 8'h00; bus_a.vec_ready = 1'b0;
    bus_b.int_req = 1'b0; bus_b.int_en = 1'b0; bus_b.data_in = 8'h00; bus_b.vec_ready = 1'b0;
    #1;
    test_reset();
    test_default();
    test_int_en_gate();
    test_three_pulse();
    test_spurious_hold();
    test_reset_mid();
    test_data_window();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
